// File: rtl/kernel_pr_start_pkg.sv
// Shared types and defaults for the dataflow start-token consumer.
package kernel_pr_start_pkg;

    // Consumer FSM encoding; the numeric values are visible on state_dbg.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        FWD   = 2'd3
    } kps_state_e;

    // Default width of the completed-invocation counter.
    localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/kernel_pr_start_consumer.sv
// Start-token consumer for a dataflow task.
// It pops one token from the upstream start FIFO and raises ap_start.
// It waits for ap_done. It then optionally forwards the token to the downstream
// start FIFO. It holds at most one token at a time.
//
// Handshakes: in_read pops when in_empty_n is also high.
// out_write pushes when out_full_n is also high.
// While out_write waits for out_full_n, out_write and out_din stay stable.
// task_start is held until task_ready is seen.
module kernel_pr_start_consumer
    import kernel_pr_start_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter bit FWD_EN     = 1'b1,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_empty_n,
    output logic                  in_read,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  task_start,
    input  logic                  task_ready,
    input  logic                  task_done,
    input  logic                  out_full_n,
    output logic                  out_write,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  token_count,
    output logic [1:0]            state_dbg
);

    kps_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tok_q, tok_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  complete;

    // The invocation finishes on ready+done together in START, or on done in RUN.
    always_comb begin
        complete = 1'b0;
        if (state_q == START && task_ready && task_done) begin
            complete = 1'b1;
        end
        if (state_q == RUN && task_done) begin
            complete = 1'b1;
        end
    end

    // Next-state, datapath and handshake outputs; reset masks every request strobe.
    always_comb begin
        state_d    = state_q;
        tok_d      = tok_q;
        cnt_d      = cnt_q;
        in_read    = 1'b0;
        task_start = 1'b0;
        out_write  = 1'b0;
        out_din    = '0;
        case (state_q)
            IDLE: begin
                in_read = in_empty_n;
                if (in_empty_n) begin
                    tok_d   = in_dout;
                    state_d = START;
                end
            end
            START: begin
                task_start = 1'b1;
                if (task_ready && !task_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // task_ready is ignored here; only done matters
            end
            FWD: begin
                out_write = 1'b1;
                out_din   = tok_q;
                if (out_full_n) begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (complete) begin
            if (FWD_EN) begin
                state_d = FWD;
            end else begin
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = IDLE;
            end
        end
        if (reset) begin
            in_read    = 1'b0;
            task_start = 1'b0;
            out_write  = 1'b0;
            out_din    = '0;
        end
    end

    // State, held token and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tok_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = (state_q != IDLE) && !reset;
    assign token_count = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_kernel_pr_start_consumer.sv
// Directed bench for kernel_pr_start_consumer with a forwarded-token scoreboard.
`timescale 1ns/1ps
module tb_kernel_pr_start_consumer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (forwarding, 8-bit tokens) ----------------
    logic        in_empty_n = 1'b0;
    logic        in_read;
    logic [7:0]  in_dout = '0;
    logic        task_start;
    logic        task_ready = 1'b0;
    logic        task_done = 1'b0;
    logic        out_full_n = 1'b1;
    logic        out_write;
    logic [7:0]  out_din;
    logic        busy;
    logic [15:0] token_count;
    logic [1:0]  state_dbg;

    kernel_pr_start_consumer #(.DATA_WIDTH(8), .FWD_EN(1'b1), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .in_empty_n(in_empty_n), .in_read(in_read), .in_dout(in_dout),
        .task_start(task_start), .task_ready(task_ready), .task_done(task_done),
        .out_full_n(out_full_n), .out_write(out_write), .out_din(out_din),
        .busy(busy), .token_count(token_count), .state_dbg(state_dbg)
    );

    // ---------------- second DUT (no forwarding, 2-bit counter) ----------------
    logic       nf_in_empty_n = 1'b0;
    logic       nf_in_read;
    logic [7:0] nf_in_dout = 8'h5a;
    logic       nf_task_start;
    logic       nf_task_ready = 1'b1;
    logic       nf_task_done = 1'b1;
    logic       nf_out_full_n = 1'b1;
    logic       nf_out_write;
    logic [7:0] nf_out_din;
    logic       nf_busy;
    logic [1:0] nf_token_count;
    logic [1:0] nf_state_dbg;

    kernel_pr_start_consumer #(.DATA_WIDTH(8), .FWD_EN(1'b0), .CNT_WIDTH(2)) dut_nf (
        .clk(clk), .reset(reset),
        .in_empty_n(nf_in_empty_n), .in_read(nf_in_read), .in_dout(nf_in_dout),
        .task_start(nf_task_start), .task_ready(nf_task_ready), .task_done(nf_task_done),
        .out_full_n(nf_out_full_n), .out_write(nf_out_write), .out_din(nf_out_din),
        .busy(nf_busy), .token_count(nf_token_count), .state_dbg(nf_state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] up_q[$];
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_push   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void refresh_up();
        in_empty_n = (up_q.size() > 0);
        in_dout    = (up_q.size() > 0) ? up_q[0] : 8'h00;
    endfunction

    // Stimulus: queue a token upstream and expect it forwarded downstream.
    task automatic add_token(input logic [7:0] v);
        up_q.push_back(v);
        exp_q.push_back(v);
        refresh_up();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Upstream FIFO model: pop when the DUT read at the edge.
    always begin
        logic rd;
        @(posedge clk);
        rd = in_read;
        #1;
        if (rd && up_q.size() > 0) void'(up_q.pop_front());
        refresh_up();
    end

    // Monitor: compare every downstream push against the expected queue.
    always @(negedge clk) begin
        if (out_write && out_full_n) begin
            n_push++;
            if (exp_q.size() == 0) chk("unexpected_push", 32'(out_din), 32'hffff_ffff);
            else chk("push_data", 32'(out_din), 32'(exp_q.pop_front()));
        end
        if (!out_write) chk("out_din_zero_idle", 32'(out_din), 32'h0);
        if (in_read) chk("in_read_only_idle", 32'(busy), 32'h0);
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int guard;
        // Reset with a token waiting: nothing may be popped.
        repeat (2) @(posedge clk);
        #2;
        add_token(8'h01);
        #1;
        chk("rst_in_read", 32'(in_read), 0);
        chk("rst_task_start", 32'(task_start), 0);
        chk("rst_out_write", 32'(out_write), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(token_count), 0);
        tick();
        reset = 1'b0;

        // Basic invocation: ready at cycle 2, done at cycle 5.
        #1 chk("s1_c0_in_read", 32'(in_read), 1);
        tick(); #1;
        chk("s1_c1_task_start", 32'(task_start), 1);
        chk("s1_c1_busy", 32'(busy), 1);
        tick(); task_ready = 1'b1; #1;
        chk("s1_c2_task_start", 32'(task_start), 1);
        tick(); task_ready = 1'b0; #1;
        chk("s1_c3_task_start", 32'(task_start), 0);
        chk("s1_c3_state", 32'(state_dbg), 2);
        tick(); #1;
        chk("s1_c4_out_write", 32'(out_write), 0);
        tick(); task_done = 1'b1; #1;
        chk("s1_c5_out_write", 32'(out_write), 0);
        tick(); task_done = 1'b0; #1;
        chk("s1_c6_out_write", 32'(out_write), 1);
        chk("s1_c6_out_din", 32'(out_din), 32'h01);
        tick(); #1;
        chk("s1_count", 32'(token_count), 1);
        chk("s1_busy", 32'(busy), 0);

        // Ready and done together in START: RUN is skipped.
        add_token(8'ha5);
        #1 chk("s2_in_read", 32'(in_read), 1);
        tick(); task_ready = 1'b1; task_done = 1'b1; #1;
        chk("s2_task_start", 32'(task_start), 1);
        tick(); task_ready = 1'b0; task_done = 1'b0; #1;
        chk("s2_out_write", 32'(out_write), 1);
        chk("s2_out_din", 32'(out_din), 32'ha5);
        tick(); #1;
        chk("s2_count", 32'(token_count), 2);

        // Downstream full for 4 cycles with another token waiting upstream.
        out_full_n = 1'b0;
        add_token(8'h3c);
        tick(); task_ready = 1'b1;
        tick(); task_ready = 1'b0; task_done = 1'b1;
        tick(); task_done = 1'b0;
        add_token(8'h77);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s3_stall_write", 32'(out_write), 1);
            chk("s3_stall_din", 32'(out_din), 32'h3c);
            chk("s3_stall_no_read", 32'(in_read), 0);
            tick();
        end
        out_full_n = 1'b1; #1;
        chk("s3_release_write", 32'(out_write), 1);
        chk("s3_release_din", 32'(out_din), 32'h3c);
        tick(); #1;
        chk("s3_count", 32'(token_count), 3);
        chk("s3_backtoback_read", 32'(in_read), 1);

        // Three queued tokens with an instantly ready/done task.
        task_ready = 1'b1; task_done = 1'b1;
        add_token(8'h11);
        add_token(8'h22);
        guard = 0;
        while (!(up_q.size() == 0 && exp_q.size() == 0 && !busy) && guard < 40) begin
            tick();
            guard++;
        end
        chk("s4_drain_in_time", 32'(guard < 40), 1);
        task_ready = 1'b0; task_done = 1'b0; #1;
        chk("s4_count", 32'(token_count), 6);
        chk("s4_pushes", 32'(n_push), 6);

        // Reset while RUN: token discarded, counter cleared, late done ignored.
        add_token(8'h99);
        tick(); task_ready = 1'b1;
        tick(); task_ready = 1'b0; #1;
        chk("s5_run_busy", 32'(busy), 1);
        chk("s5_run_state", 32'(state_dbg), 2);
        reset = 1'b1;
        void'(exp_q.pop_back());
        #1 chk("s5_rst_busy", 32'(busy), 0);
        tick(); reset = 1'b0; #1;
        chk("s5_idle_state", 32'(state_dbg), 0);
        chk("s5_idle_busy", 32'(busy), 0);
        chk("s5_count", 32'(token_count), 0);
        task_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("s5_done_ignored_write", 32'(out_write), 0);
            chk("s5_done_ignored_busy", 32'(busy), 0);
        end
        task_done = 1'b0;
        chk("s5_pushes", 32'(n_push), 6);

        // No-forward instance: 5 invocations on a 2-bit counter.
        for (int k = 1; k <= 5; k++) begin
            nf_in_empty_n = 1'b1; #1;
            chk("s6_in_read", 32'(nf_in_read), 1);
            tick();
            nf_in_empty_n = 1'b0; #1;
            chk("s6_task_start", 32'(nf_task_start), 1);
            chk("s6_no_write", 32'(nf_out_write), 0);
            tick(); #1;
            chk("s6_idle", 32'(nf_busy), 0);
            chk("s6_no_write_idle", 32'(nf_out_write), 0);
            if (k == 4) chk("s6_wrap", 32'(nf_token_count), 0);
        end
        chk("s6_count", 32'(nf_token_count), 1);

        tick();
        chk("final_exp_q_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kernel_pr_start_consumer.md
KERNEL_PR_START_CONSUMER -- requirements
Module: kernel_pr_start_consumer

Interface
REQ-001 Parameter DATA_WIDTH, default 1: width of a start token.
REQ-002 Parameter FWD_EN, default 1: 1 = forward each consumed token downstream after task completion; 0 = no forwarding.
REQ-003 Parameter CNT_WIDTH, default 16: width of the completed-token counter.
REQ-004 clk  input  1  clock; all logic on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_empty_n  input  1  upstream start FIFO holds a token.
REQ-007 in_read  output  1  pop one token from the upstream start FIFO.
REQ-008 in_dout  input  DATA_WIDTH  head token of the upstream start FIFO.
REQ-009 task_start  output  1  ap_start to the controlled dataflow task.
REQ-010 task_ready  input  1  task accepted the start (ap_ready).
REQ-011 task_done  input  1  task finished (ap_done).
REQ-012 out_full_n  input  1  downstream start FIFO has space.
REQ-013 out_write  output  1  push one token into the downstream start FIFO.
REQ-014 out_din  output  DATA_WIDTH  token pushed downstream.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 token_count  output  CNT_WIDTH  number of completed invocations.

Function
REQ-017 The FSM SHALL have four states: IDLE, START, RUN, FWD.
REQ-018 In IDLE, in_read SHALL equal in_empty_n combinationally; on a pop, in_dout SHALL be latched into tok_reg and the state SHALL move to START.
REQ-019 in_read SHALL never be asserted outside IDLE, so the block holds at most one token at a time.
REQ-020 In START, task_start SHALL be 1; on task_ready=1 the state SHALL leave START, and task_start SHALL be 0 from the next cycle.
REQ-021 task_ready=1 and task_done=0 in START SHALL go to RUN; task_ready=1 and task_done=1 in the same cycle SHALL skip RUN and complete the invocation.
REQ-022 In RUN, task_done=1 SHALL complete the invocation; task_ready in RUN SHALL be ignored.
REQ-023 On completion, the state SHALL go to FWD if FWD_EN=1, else to IDLE with token_count incremented.
REQ-024 In FWD, out_write SHALL be 1 and out_din SHALL equal tok_reg, both held stable until out_full_n=1.
REQ-025 A push occurs when out_write=1 and out_full_n=1; that cycle SHALL increment token_count and move to IDLE.
REQ-026 task_done in IDLE or FWD SHALL be ignored.
REQ-027 Latency: token present at cycle 0 (IDLE) -> task_start=1 at cycle 1; done at cycle N -> out_write=1 at cycle N+1.
REQ-028 Back-to-back operation: the cycle after a push (IDLE) SHALL pop again if in_empty_n=1.
REQ-029 token_count SHALL wrap modulo 2^CNT_WIDTH without saturation.
REQ-030 out_din SHALL be 0 outside FWD.

Reset
REQ-031 While reset=1, the state SHALL go to IDLE and in_read, task_start and out_write SHALL be forced to 0.
REQ-032 Reset SHALL clear tok_reg and token_count to 0 and drive busy to 0.
REQ-033 A reset in any state SHALL discard the held token without forwarding it, and SHALL NOT pop upstream in the reset cycle.

Structure
REQ-034 Package kernel_pr_start_pkg SHALL hold the state enum (IDLE=0, START=1, RUN=2, FWD=3) and the CNT_WIDTH default.
REQ-035 The block SHALL be a single module with no sub-module; the FIFOs it connects to are instantiated externally.

Verification
REQ-036 Scenario: in_empty_n=1, in_dout=1, task_ready at cycle 2, task_done at cycle 5, out_full_n=1 -> in_read at cycle 0, task_start high cycles 1-2, out_write at cycle 6 with out_din=1, token_count=1.
REQ-037 Scenario: task_ready=task_done=1 in the same START cycle -> RUN skipped, out_write on the next cycle.
REQ-038 Scenario: out_full_n=0 for 4 cycles in FWD -> out_write held for 5 cycles, out_din stable, exactly one push, no in_read during the stall.
REQ-039 Scenario: 3 tokens queued upstream, task ready and done immediately -> 3 pops, 3 pushes in order, token_count=3, in_read never asserted outside IDLE.
REQ-040 Scenario: reset asserted in RUN -> next cycle IDLE, busy=0, token_count=0, no out_write; a later task_done is ignored.
REQ-041 Scenario: FWD_EN=0 with CNT_WIDTH=2 and 5 invocations -> out_write never asserted, token_count=1.
